// File: rtl/rom_ram_scan_ctrl.sv
// rom_ram_scan_ctrl
//   Single-clock synchronous memory (DEPTH = 2**ADDR_W words of DATA_W bits).
//   It has an external write port and a fully pipelined read port. After every
//   reset, a sequencer loads either a zero or an identity pattern. A scan engine
//   then sweeps every address and reports the XOR of all words it read.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   wr_en       write request (accepted outside INIT)
//   wr_addr     write address
//   wr_data     write data
//   rd_en       external read request (accepted in IDLE only)
//   rd_addr     external read address
//   scan_start  start a sweep (sampled in IDLE only)
//   ready       high in IDLE and SCAN
//   rd_data     registered read data
//   rd_valid    rd_data valid this cycle
//   rd_tag      address that produced rd_data
//   scan_busy   high in SCAN and DRAIN
//   scan_done   one-cycle pulse with the last beat of a sweep
//   scan_xor    checksum of the last completed sweep
module rom_ram_scan_ctrl #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 6,
  parameter int INIT_MODE = 1,
  parameter int RD_LAT    = 1   // 1 or 2; any value other than 2 behaves as 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              scan_start,
  output logic              ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] rd_tag,
  output logic              scan_busy,
  output logic              scan_done,
  output logic [DATA_W-1:0] scan_xor
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] CNT_END  = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    st_init,
    st_idle,
    st_scan,
    st_drain
  } state_t;

  state_t            state;
  // Shared counter: it is the init write address in INIT and the sweep address
  // in SCAN. The extra MSB lets INIT see the terminal count DEPTH.
  logic [ADDR_W:0]   cnt;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              issue_ext;
  logic              issue_scan;
  logic              issue;
  logic [ADDR_W-1:0] rd_a;

  logic [DATA_W-1:0] src_data;
  logic [ADDR_W-1:0] src_tag;
  logic              src_vld;
  logic              src_scan;

  function automatic logic [DATA_W-1:0] init_word(input logic [ADDR_W-1:0] a);
    if (INIT_MODE == 0) return '0;
    return DATA_W'(a);   // identity pattern, i mod 2**DATA_W
  endfunction

  // A scan_start in IDLE takes priority over an external read in the same cycle.
  always_comb begin
    issue_ext  = (state == st_idle) && rd_en && !scan_start;
    issue_scan = (state == st_scan);
    issue      = issue_ext || issue_scan;
    rd_a       = issue_scan ? cnt[ADDR_W-1:0] : rd_addr;
  end

  // Memory write port. INIT owns the port, and external writes are blocked
  // until INIT finishes. The storage itself is never cleared by rst.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == st_init) begin
        if (!cnt[ADDR_W]) mem[cnt[ADDR_W-1:0]] <= init_word(cnt[ADDR_W-1:0]);
      end else if (wr_en) begin
        mem[wr_addr] <= wr_data;
      end
    end
  end

  // The memory is read before the write of the same edge lands, so a
  // read-during-write to one address returns the old word.
  generate
    if (RD_LAT == 2) begin : g_lat2
      logic [DATA_W-1:0] data_p0;
      logic [ADDR_W-1:0] tag_p0;
      logic              vld_p0;
      logic              scan_p0;

      // ---- stage p0: memory array read ----
      always_ff @(posedge clk) begin
        data_p0 <= mem[rd_a];
        tag_p0  <= rd_a;
        if (rst) begin
          vld_p0  <= 1'b0;
          scan_p0 <= 1'b0;
        end else begin
          vld_p0  <= issue;
          scan_p0 <= issue_scan;
        end
      end

      assign src_data = data_p0;
      assign src_tag  = tag_p0;
      assign src_vld  = vld_p0;
      assign src_scan = scan_p0;
    end else begin : g_lat1
      assign src_data = mem[rd_a];
      assign src_tag  = rd_a;
      assign src_vld  = issue;
      assign src_scan = issue_scan;
    end
  endgenerate

  // ---- output stage and control FSM ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= st_init;
      cnt       <= '0;
      ready     <= 1'b0;
      scan_busy <= 1'b0;
      scan_done <= 1'b0;
      scan_xor  <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      rd_tag    <= '0;
    end else begin
      rd_valid  <= src_vld;
      scan_done <= 1'b0;
      if (src_vld) begin
        rd_data <= src_data;
        rd_tag  <= src_tag;
      end
      // Sweep beats fold into the checksum in the same edge that registers
      // them. The final beat therefore lands scan_xor and scan_done together.
      if (src_vld && src_scan) begin
        acc <= acc ^ src_data;
        if (src_tag == '1) begin
          scan_xor  <= acc ^ src_data;
          scan_done <= 1'b1;
        end
      end

      case (state)
        st_init: begin
          if (cnt == CNT_END) begin
            state <= st_idle;
            ready <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        st_idle: begin
          if (scan_start) begin
            state     <= st_scan;
            scan_busy <= 1'b1;
            cnt       <= '0;
            acc       <= '0;
          end
        end
        st_scan: begin
          if (cnt == CNT_LAST) begin
            state <= st_drain;
            ready <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        st_drain: begin
          // scan_done is high during the last DRAIN cycle, so leave on it.
          if (scan_done) begin
            state     <= st_idle;
            ready     <= 1'b1;
            scan_busy <= 1'b0;
          end
        end
        default: state <= st_init;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_ram_scan_ctrl.sv
// Testbench for rom_ram_scan_ctrl. Four instances share one stimulus stream:
//   i0: DATA_W=8 identity, RD_LAT=1    i1: DATA_W=8 identity, RD_LAT=2
//   i2: DATA_W=4 zeros,    RD_LAT=1    i3: DATA_W=4 identity, RD_LAT=1
// A behavioural model tracks, for each instance, its memory contents, its
// operating phase and the reads in flight. Every output is checked every cycle.
module tb_rom_ram_scan_ctrl;

  localparam int P_INIT  = 0;
  localparam int P_IDLE  = 1;
  localparam int P_SCAN  = 2;
  localparam int P_DRAIN = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       wr_en;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [5:0] rd_addr;
  logic       scan_start;

  logic [7:0] d0, d1, x0, x1;
  logic [3:0] d2, d3, x2, x3;
  logic [5:0] tg  [4];
  logic       rdy [4];
  logic       vl  [4];
  logic       bz  [4];
  logic       dn  [4];
  logic [7:0] od  [4];
  logic [7:0] ox  [4];

  assign od[0] = d0;
  assign od[1] = d1;
  assign od[2] = {4'h0, d2};
  assign od[3] = {4'h0, d3};
  assign ox[0] = x0;
  assign ox[1] = x1;
  assign ox[2] = {4'h0, x2};
  assign ox[3] = {4'h0, x3};

  rom_ram_scan_ctrl #(.DATA_W(8), .ADDR_W(6), .INIT_MODE(1), .RD_LAT(1)) u0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .scan_start(scan_start), .ready(rdy[0]),
    .rd_data(d0), .rd_valid(vl[0]), .rd_tag(tg[0]), .scan_busy(bz[0]),
    .scan_done(dn[0]), .scan_xor(x0));

  rom_ram_scan_ctrl #(.DATA_W(8), .ADDR_W(6), .INIT_MODE(1), .RD_LAT(2)) u1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .scan_start(scan_start), .ready(rdy[1]),
    .rd_data(d1), .rd_valid(vl[1]), .rd_tag(tg[1]), .scan_busy(bz[1]),
    .scan_done(dn[1]), .scan_xor(x1));

  rom_ram_scan_ctrl #(.DATA_W(4), .ADDR_W(6), .INIT_MODE(0), .RD_LAT(1)) u2 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data[3:0]),
    .rd_en(rd_en), .rd_addr(rd_addr), .scan_start(scan_start), .ready(rdy[2]),
    .rd_data(d2), .rd_valid(vl[2]), .rd_tag(tg[2]), .scan_busy(bz[2]),
    .scan_done(dn[2]), .scan_xor(x2));

  rom_ram_scan_ctrl #(.DATA_W(4), .ADDR_W(6), .INIT_MODE(1), .RD_LAT(1)) u3 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data[3:0]),
    .rd_en(rd_en), .rd_addr(rd_addr), .scan_start(scan_start), .ready(rdy[3]),
    .rd_data(d3), .rd_valid(vl[3]), .rd_tag(tg[3]), .scan_busy(bz[3]),
    .scan_done(dn[3]), .scan_xor(x3));

  // Reference model state, one slot per instance
  int         lat   [4] = '{1, 2, 1, 1};
  int         imode [4] = '{1, 1, 0, 1};
  logic [7:0] msk   [4] = '{8'hFF, 8'hFF, 8'h0F, 8'h0F};
  logic [7:0] mm    [4][64];
  int         ph    [4];
  int         icnt  [4];
  int         sw    [4];
  int         dl    [4];
  logic [7:0] macc  [4];
  logic [7:0] xr    [4];
  logic       edone [4];
  logic       hv    [4][3];   // [1] = read issued at the latest edge, [2] = one edge earlier
  logic       hs    [4][3];
  logic [5:0] ha    [4][3];
  logic [7:0] hd    [4][3];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance the model of instance i across one rising edge.
  task automatic model_edge(input int i, input logic we, input logic [5:0] wa,
                            input logic [7:0] wd, input logic re, input logic [5:0] ra,
                            input logic ss);
    logic       iv, is;
    logic [5:0] ia;
    logic [7:0] id;
    int         pre;
    int         l;
    iv = 1'b0; is = 1'b0; ia = '0; id = '0; pre = ph[i];
    if (rst) begin
      ph[i] = P_INIT; icnt[i] = 0; xr[i] = 8'h00; edone[i] = 1'b0;
      for (int k = 0; k < 3; k++) begin hv[i][k] = 1'b0; hs[i][k] = 1'b0; end
      return;
    end
    case (ph[i])
      P_INIT: begin
        if (icnt[i] == 64) begin
          ph[i] = P_IDLE;
          for (int a = 0; a < 64; a++)
            mm[i][a] = (imode[i] != 0) ? (8'(a) & msk[i]) : 8'h00;
        end else begin
          icnt[i]++;
        end
      end
      P_IDLE: begin
        if (ss) begin
          ph[i] = P_SCAN; sw[i] = 0; macc[i] = 8'h00;
        end else if (re) begin
          iv = 1'b1; ia = ra;
        end
      end
      P_SCAN: begin
        iv = 1'b1; is = 1'b1; ia = 6'(sw[i]);
        if (sw[i] == 63) begin ph[i] = P_DRAIN; dl[i] = lat[i]; end
        else sw[i]++;
      end
      default: begin
        dl[i]--;
        if (dl[i] == 0) ph[i] = P_IDLE;
      end
    endcase
    if (iv) begin
      id = mm[i][ia];
      if (is) macc[i] = macc[i] ^ id;
    end
    if (pre != P_INIT && we) mm[i][wa] = wd & msk[i];
    hv[i][2] = hv[i][1]; hs[i][2] = hs[i][1]; ha[i][2] = ha[i][1]; hd[i][2] = hd[i][1];
    hv[i][1] = iv;       hs[i][1] = is;       ha[i][1] = ia;       hd[i][1] = id;
    l = lat[i];
    edone[i] = hv[i][l] && hs[i][l] && (ha[i][l] == 6'd63);
    if (edone[i]) xr[i] = macc[i];
  endtask

  task automatic check_out(input int i);
    int l;
    l = lat[i];
    chk($sformatf("i%0d_ready", i), 32'(rdy[i]), 32'(ph[i] == P_IDLE || ph[i] == P_SCAN));
    chk($sformatf("i%0d_busy", i), 32'(bz[i]), 32'(ph[i] == P_SCAN || ph[i] == P_DRAIN));
    chk($sformatf("i%0d_valid", i), 32'(vl[i]), 32'(hv[i][l]));
    chk($sformatf("i%0d_done", i), 32'(dn[i]), 32'(edone[i]));
    chk($sformatf("i%0d_xor", i), 32'(ox[i]), 32'(xr[i]));
    if (rst) begin
      chk($sformatf("i%0d_rst_data", i), 32'(od[i]), 32'h0);
      chk($sformatf("i%0d_rst_tag", i), 32'(tg[i]), 32'h0);
    end else if (hv[i][l]) begin
      chk($sformatf("i%0d_data", i), 32'(od[i]), 32'(hd[i][l]));
      chk($sformatf("i%0d_tag", i), 32'(tg[i]), 32'(ha[i][l]));
    end
  endtask

  // Drive one cycle of inputs, then update the model and check all instances.
  task automatic step(input logic we, input logic [5:0] wa, input logic [7:0] wd,
                      input logic re, input logic [5:0] ra, input logic ss);
    wr_en = we; wr_addr = wa; wr_data = wd; rd_en = re; rd_addr = ra; scan_start = ss;
    @(posedge clk);
    for (int i = 0; i < 4; i++) model_edge(i, we, wa, wd, re, ra, ss);
    #1;
    for (int i = 0; i < 4; i++) check_out(i);
  endtask

  task automatic step_rand_idle(input int n);
    for (int k = 0; k < n; k++)
      step(1'($urandom), 6'($urandom), 8'($urandom), 1'($urandom), 6'($urandom), 1'b0);
  endtask

  // One full sweep, with an external read colliding on the start cycle.
  // Optionally there are random writes during the sweep. Stray scan_start
  // pulses are applied while every instance is still sweeping.
  task automatic do_scan(input bit wr_rand);
    int nb [4];
    int nv [4];
    int nd [4];
    for (int i = 0; i < 4; i++) begin nb[i] = 0; nv[i] = 0; nd[i] = 0; end
    for (int k = 0; k <= 70; k++) begin
      logic we;
      logic ss;
      we = wr_rand ? 1'($urandom) : 1'b0;
      ss = (k == 0) ? 1'b1 : ((k < 60) ? 1'($urandom) : 1'b0);
      step(we, 6'($urandom), 8'($urandom), (k == 0), 6'($urandom), ss);
      for (int i = 0; i < 4; i++) begin
        nb[i] += int'(bz[i]);
        nv[i] += int'(vl[i]);
        nd[i] += int'(dn[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("i%0d_busy_cycles", i), 32'(nb[i]), 32'(64 + lat[i]));
      chk($sformatf("i%0d_scan_beats", i), 32'(nv[i]), 32'd64);
      chk($sformatf("i%0d_done_pulses", i), 32'(nd[i]), 32'd1);
    end
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_en = 1'b0; rd_addr = '0; scan_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ph[i] = P_INIT; icnt[i] = 0; sw[i] = 0; dl[i] = 0;
      macc[i] = 8'h00; xr[i] = 8'h00; edone[i] = 1'b0;
      for (int k = 0; k < 3; k++) begin hv[i][k] = 1'b0; hs[i][k] = 1'b0; ha[i][k] = '0; hd[i][k] = '0; end
      for (int a = 0; a < 64; a++) mm[i][a] = 8'h00;
    end

    repeat (3) step(1'b0, 6'd0, 8'd0, 1'b0, 6'd0, 1'b0);
    rst = 1'b0;

    // INIT with random traffic, all of which is ignored; ready only on edge 65
    for (int k = 0; k < 64; k++)
      step(1'($urandom), 6'($urandom), 8'($urandom), 1'($urandom), 6'($urandom), 1'($urandom));
    chk("ready_before_65", 32'(rdy[0]), 32'd0);
    step(1'($urandom), 6'($urandom), 8'($urandom), 1'($urandom), 6'($urandom), 1'($urandom));
    chk("ready_at_65", 32'(rdy[0]), 32'd1);

    // Single reads
    step(1'b0, 6'd0, 8'd0, 1'b1, 6'd5, 1'b0);
    chk("rd5_data", 32'(od[0]), 32'h05);
    chk("rd5_tag", 32'(tg[0]), 32'd5);
    step(1'b0, 6'd0, 8'd0, 1'b1, 6'd63, 1'b0);
    chk("rd63_data", 32'(od[0]), 32'h3F);
    chk("rd63_narrow_id", 32'(od[3]), 32'h0F);
    chk("rd63_narrow_zero", 32'(od[2]), 32'h00);
    chk("lat2_rd5", 32'(od[1]), 32'h05);

    // Back-to-back reads 0..3
    for (int a = 0; a < 4; a++) begin
      step(1'b0, 6'd0, 8'd0, 1'b1, 6'(a), 1'b0);
      chk("b2b_data", 32'(od[0]), 32'(a));
    end
    step(1'b0, 6'd0, 8'd0, 1'b1, 6'h23, 1'b0);
    chk("narrow_id_0x23", 32'(od[3]), 32'h3);
    repeat (3) step(1'b0, 6'd0, 8'd0, 1'b0, 6'd0, 1'b0);

    // Sweep of the fresh pattern
    do_scan(1'b0);
    chk("fresh_xor", 32'(ox[0]), 32'h00);
    chk("fresh_xor_narrow", 32'(ox[3]), 32'h0);

    // Read-during-write is read-first
    step(1'b1, 6'd5, 8'hA5, 1'b1, 6'd5, 1'b0);
    chk("rdw_old", 32'(od[0]), 32'h05);
    step(1'b0, 6'd0, 8'd0, 1'b1, 6'd5, 1'b0);
    chk("rdw_new", 32'(od[0]), 32'hA5);
    repeat (2) step(1'b0, 6'd0, 8'd0, 1'b0, 6'd0, 1'b0);

    do_scan(1'b0);
    chk("rescan_xor", 32'(ox[0]), 32'hA0);
    chk("rescan_xor_lat2", 32'(ox[1]), 32'hA0);

    // Random traffic, then a sweep with writes racing the sweep address
    step_rand_idle(150);
    repeat (2) step(1'b0, 6'd0, 8'd0, 1'b0, 6'd0, 1'b0);
    do_scan(1'b1);
    step_rand_idle(40);
    repeat (2) step(1'b0, 6'd0, 8'd0, 1'b0, 6'd0, 1'b0);

    // Reset in the middle of a sweep (beat 20 visible on the lat-1 instances)
    step(1'b1, 6'd5, 8'hA5, 1'b0, 6'd0, 1'b0);
    step(1'b0, 6'd0, 8'd0, 1'b0, 6'd0, 1'b1);
    repeat (21) step(1'b0, 6'd0, 8'd0, 1'b0, 6'd0, 1'b0);
    chk("beat20_tag", 32'(tg[0]), 32'd20);
    rst = 1'b1;
    step(1'b0, 6'd0, 8'd0, 1'b0, 6'd0, 1'b0);
    chk("abort_valid", 32'(vl[0]), 32'd0);
    chk("abort_done", 32'(dn[0]), 32'd0);
    chk("abort_xor", 32'(ox[0]), 32'h00);
    rst = 1'b0;
    for (int k = 0; k < 65; k++)
      step(1'($urandom), 6'($urandom), 8'($urandom), 1'($urandom), 6'($urandom), 1'($urandom));
    step(1'b0, 6'd0, 8'd0, 1'b1, 6'd5, 1'b0);
    chk("restored_addr5", 32'(od[0]), 32'h05);
    step(1'b0, 6'd0, 8'd0, 1'b0, 6'd0, 1'b0);

    do_scan(1'b1);
    step_rand_idle(30);
    repeat (3) step(1'b0, 6'd0, 8'd0, 1'b0, 6'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/rom_ram_scan_ctrl.md
Name: rom_ram_scan_ctrl

Overview:
- Parametrised successor to the fixed 64x8 identity-pattern lookup memory: single-clock synchronous memory with a write port and a pipelined read port.
- A hardware init sequencer loads the identity/zero pattern after every reset.
- A scan engine sweeps all addresses in order and reports an XOR checksum.
- Used as lab datapath storage and as a self-checking memory sweep replacing bench-driven address walks.

Parameters:
DATA_W, 8, data word width (>=1)
ADDR_W, 6, address width; DEPTH = 2**ADDR_W
INIT_MODE, 1, 0 = load zeros, 1 = load identity (word[i] = i mod 2**DATA_W)
RD_LAT, 1, read latency in cycles; legal values 1 or 2

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
wr_en  in  1  write request
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
rd_en  in  1  read request (external)
rd_addr  in  ADDR_W  read address
scan_start  in  1  start sweep (level sampled per cycle)
ready  out  1  high in IDLE and SCAN; external writes accepted
rd_data  out  DATA_W  read data, registered
rd_valid  out  1  rd_data valid this cycle
rd_tag  out  ADDR_W  address that produced rd_data
scan_busy  out  1  high in SCAN and DRAIN
scan_done  out  1  one-cycle pulse at sweep end
scan_xor  out  DATA_W  checksum of last completed sweep

Behaviour:
- Single clock, synchronous active-high reset; all state changes on rising clk.
- Reset values: ready=0, rd_valid=0, rd_data=0, rd_tag=0, scan_busy=0, scan_done=0, scan_xor=0; read pipeline valids cleared; FSM -> INIT with init counter 0.
- Memory contents are not cleared by rst directly; the INIT state rewrites them.
- FSM states: INIT, IDLE, SCAN, DRAIN.
- INIT:
  - Writes the pattern to address = counter, one word per cycle.
  - After DEPTH cycles (last address written), go to IDLE; ready=1 from the next cycle.
  - With defaults, ready rises on the 65th rising edge after rst is sampled low.
  - wr_en, rd_en and scan_start are ignored in INIT.
- IDLE:
  - External rd_en accepted every cycle; rd_valid/rd_data/rd_tag appear exactly RD_LAT cycles later.
  - Reads are fully pipelined, one per cycle.
- Writes: accepted in IDLE, SCAN and DRAIN; take effect at that clock edge.
- Read-during-write to the same address is read-first: the read returns the old data.
- scan_start in IDLE:
  - Enter SCAN and clear the internal accumulator.
  - Issue internal reads to addresses 0..DEPTH-1, one per cycle.
  - External rd_en is ignored while scan_busy=1.
- After the last issue, go to DRAIN for RD_LAT cycles.
- Every rd_valid beat during a sweep (rd_tag 0..DEPTH-1) XORs rd_data into the accumulator.
- Last beat:
  - scan_xor is updated to the final accumulator value.
  - scan_done pulses in the same cycle as the last rd_valid beat.
  - FSM returns to IDLE in that cycle.
- scan_xor holds until the next completed sweep. It is not updated by an aborted sweep.
- scan_start outside IDLE is ignored (not queued).
- If scan_start and rd_en are both high in IDLE, the scan wins and the external read is dropped.
- Writes during SCAN to an address not yet swept are reflected in the checksum; writes to already-swept addresses are not.
- Reset mid-INIT/SCAN/DRAIN:
  - Aborts immediately.
  - In-flight reads are discarded (no rd_valid).
  - INIT restarts from address 0.
- Address and counter arithmetic is unsigned, ADDR_W+1 bits internally for terminal detect. No wrap beyond DEPTH-1.

Test Plan:
- Defaults. Hold rst 3 cycles, release -> ready=0 for 64 cycles, then 1. Read addr 5 -> rd_valid 1 cycle later, rd_data=0x05, rd_tag=5. Read addr 63 -> 0x3F.
- Back-to-back reads of addr 0..3 on consecutive cycles -> 0x00,0x01,0x02,0x03 on consecutive cycles, rd_valid held high 4 cycles. Repeat with RD_LAT=2 -> same data, shifted one cycle.
- Write 0xA5 to addr 5 and read addr 5 in the same cycle -> 0x05. Read again next cycle -> 0xA5.
- Scan on fresh identity memory -> scan_busy high 64+RD_LAT cycles, 64 rd_valid beats, scan_done single pulse, scan_xor=0x00. Write 0xA5 to addr 5, rescan -> scan_xor=0xA0.
- INIT_MODE=0 with DATA_W=4, ADDR_W=6 -> all reads 0, scan_xor=0. Then INIT_MODE=1 -> read addr 0x23 returns 0x3, scan_xor=0x0.
- Assert rst at sweep beat 20 -> rd_valid=0 next cycle, no scan_done, scan_xor keeps the prior value (0x00 after reset). The written 0xA5 is restored to 0x05 after the new INIT completes.
